// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller with double-buffered host updates.
// Optional slot-start blanking: define SEG_SCAN_DEADTIME_EN.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEADTIME    = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [3*NUM_DIGITS-1:0] upd_data,
  output logic [2:0]              seg_code,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int SPAN = (DEADTIME >= REFRESH_DIV)
                      ? DEADTIME + 1 : REFRESH_DIV;
  localparam int PW = $clog2(SPAN);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           presc, presc_n;
  logic [IW-1:0]           idx, idx_n;
  logic [3*NUM_DIGITS-1:0] active, active_n;
  logic [3*NUM_DIGITS-1:0] pending, pending_n;
  logic                    pend_full, pend_full_n;
  logic                    tc, wrap, fb, take, blank;
  logic [NUM_DIGITS-1:0]   sel_n;
  logic [2:0]              code_n;

  assign tc        = enable && (presc == P_LAST);
  assign wrap      = tc && (idx == I_LAST);
  assign fb        = wrap || !enable;
  assign take      = upd_valid && !pend_full;
  assign upd_ready = !pend_full;

`ifdef SEG_SCAN_DEADTIME_EN
  localparam logic [PW-1:0] DT_CNT = PW'(DEADTIME);
  assign blank = presc < DT_CNT;
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    presc_n     = presc;
    idx_n       = idx;
    active_n    = active;
    pending_n   = pending;
    pend_full_n = pend_full;
    if (!enable) begin
      presc_n = '0;
      idx_n   = '0;
    end else if (tc) begin
      presc_n = '0;
      idx_n   = (idx == I_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc_n = presc + 1'b1;
    end
    // pend_full gates both paths, so they never collide
    if (take) begin
      pending_n   = upd_data;
      pend_full_n = 1'b1;
    end else if (fb && pend_full) begin
      active_n    = pending;
      pend_full_n = 1'b0;
    end
    sel_n = '0;
    if (enable && !blank)
      sel_n = NUM_DIGITS'(1) << idx;
    code_n = enable ? active[idx*3 +: 3] : active[2:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      active     <= '0;
      pending    <= '0;
      pend_full  <= 1'b0;
      dig_sel    <= '0;
      seg_code   <= '0;
      frame_done <= 1'b0;
    end else begin
      presc      <= presc_n;
      idx        <= idx_n;
      active     <= active_n;
      pending    <= pending_n;
      pend_full  <= pend_full_n;
      dig_sel    <= sel_n;
      seg_code   <= code_n;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl, NUM_DIGITS=4, REFRESH_DIV=4.
// Expected per-cycle outputs are queued then compared after each edge.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int DT = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          upd_valid = 1'b0;
  logic [11:0]   upd_data = '0;
  logic          upd_ready;
  logic [2:0]    seg_code;
  logic [ND-1:0] dig_sel;
  logic          frame_done;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [3:0] dig;
    logic [2:0] seg;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t sb[$];
  exp_t e, g;

  seg_scan_ctrl #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .DEADTIME   (DT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .upd_data  (upd_data),
    .seg_code  (seg_code),
    .dig_sel   (dig_sel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // k = edges since the scan started from digit 0, slot count 0
  function automatic logic [3:0] dig_at(int k);
    int p;
    p = (k - 1) % RD;
`ifdef SEG_SCAN_DEADTIME_EN
    if (p < DT) return 4'b0000;
`endif
    return 4'b0001 << (((k - 1) / RD) % ND);
  endfunction

  function automatic logic fd_at(int k);
    return (k % (RD * ND)) == 0;
  endfunction

  function automatic logic [2:0] code(logic [11:0] d, int k);
    return d[3 * (((k - 1) / RD) % ND) +: 3];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic en);
    @(negedge clk);
    rst_n = 1'b0;
    upd_valid = 1'b0;
    upd_data = '0;
    enable = en;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic show(input string nm, input int k);
    $display("FAIL %s k=%0d got dig=%b seg=%0d fd=%b rdy=%b want dig=%b seg=%0d fd=%b rdy=%b",
             nm, k, g.dig, g.seg, g.fd, g.rdy, e.dig, e.seg, e.fd, e.rdy);
  endtask

  task automatic test_reset();
    bit hit;
    do_reset(1'b0);
    g = '{dig_sel, seg_code, frame_done, upd_ready};
    e = '{4'b0000, 3'd0, 1'b0, 1'b1};
    total++;
    if (g !== e) begin bad++; show("reset_state", 0); end
    do_reset(1'b1);
    tick();
    upd_valid = 1'b1;
    upd_data = 12'hFFF;
    tick();
    upd_valid = 1'b0;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (dig_sel === 4'b0100) hit = 1;
      else tick();
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL reset_wait got dig=%b want dig=0100 within 40 cycles", dig_sel);
    end
    #1 rst_n = 1'b0;
    #1;
    g = '{dig_sel, seg_code, frame_done, upd_ready};
    e = '{4'b0000, 3'd0, 1'b0, 1'b1};
    total++;
    if (g !== e) begin bad++; show("reset_async", 0); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      sb.push_back('{dig_at(k), 3'd0, fd_at(k), 1'b1});
      tick();
      e = sb.pop_front();
      g = '{dig_sel, seg_code, frame_done, upd_ready};
      total++;
      if (g !== e) begin bad++; show("reset_restart", k); end
    end
  endtask

  task automatic test_free_scan();
    do_reset(1'b1);
    for (int k = 1; k <= 48; k++) begin
      sb.push_back('{dig_at(k), 3'd0, fd_at(k), 1'b1});
      tick();
      e = sb.pop_front();
      g = '{dig_sel, seg_code, frame_done, upd_ready};
      total++;
      if (g !== e) begin bad++; show("free_scan", k); end
    end
  endtask

  task automatic test_update();
    logic [11:0] u;
    logic [2:0]  s;
    u = 12'b011_010_001_000;
    do_reset(1'b1);
    for (int k = 1; k <= 36; k++) begin
      upd_valid = (k == 5);
      upd_data = u;
      s = (k <= 16) ? 3'd0 : code(u, k);
      sb.push_back('{dig_at(k), s, fd_at(k), (k < 5 || k >= 16)});
      tick();
      e = sb.pop_front();
      g = '{dig_sel, seg_code, frame_done, upd_ready};
      total++;
      if (g !== e) begin bad++; show("update", k); end
    end
    upd_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [11:0] a;
    logic [2:0]  s;
    logic        r;
    a = 12'b100_110_101_011;
    do_reset(1'b1);
    for (int k = 1; k <= 48; k++) begin
      upd_valid = (k <= 17);
      upd_data = (k == 1) ? a : 12'hFFF;
      if (k <= 16) s = 3'd0;
      else if (k <= 32) s = code(a, k);
      else s = 3'd7;
      r = (k == 16) || (k >= 32);
      sb.push_back('{dig_at(k), s, fd_at(k), r});
      tick();
      e = sb.pop_front();
      g = '{dig_sel, seg_code, frame_done, upd_ready};
      total++;
      if (g !== e) begin bad++; show("backpressure", k); end
    end
    upd_valid = 1'b0;
  endtask

  task automatic test_disable();
    logic [11:0] b;
    logic [2:0]  s;
    b = 12'b010_001_111_110;
    do_reset(1'b1);
    for (int k = 1; k <= 30; k++) begin
      enable = (k <= 6);
      upd_valid = (k == 9);
      upd_data = b;
      if (k <= 6) begin
        sb.push_back('{dig_at(k), 3'd0, fd_at(k), 1'b1});
      end else begin
        s = (k >= 11) ? b[2:0] : 3'd0;
        sb.push_back('{4'b0000, s, 1'b0, (k != 9)});
      end
      tick();
      e = sb.pop_front();
      g = '{dig_sel, seg_code, frame_done, upd_ready};
      total++;
      if (g !== e) begin bad++; show("disable", k); end
    end
    upd_valid = 1'b0;
    enable = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      sb.push_back('{dig_at(j), code(b, j), fd_at(j), 1'b1});
      tick();
      e = sb.pop_front();
      g = '{dig_sel, seg_code, frame_done, upd_ready};
      total++;
      if (g !== e) begin bad++; show("reenable", j); end
    end
  endtask

`ifdef SEG_SCAN_DEADTIME_EN
  task automatic test_deadtime();
    logic [3:0] pat [8];
    pat = '{4'b0000, 4'b0001, 4'b0001, 4'b0001,
            4'b0000, 4'b0010, 4'b0010, 4'b0010};
    do_reset(1'b1);
    for (int k = 1; k <= 8; k++) begin
      sb.push_back('{pat[k-1], 3'd0, 1'b0, 1'b1});
      tick();
      e = sb.pop_front();
      g = '{dig_sel, seg_code, frame_done, upd_ready};
      total++;
      if (g !== e) begin bad++; show("deadtime", k); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_free_scan();
    test_update();
    test_back_to_back();
    test_disable();
`ifdef SEG_SCAN_DEADTIME_EN
    test_deadtime();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of NUM_DIGITS common-cathode seven-segment digits that share one 3-bit segment decoder. Each digit gets one refresh slot in turn: the block presents that digit's 3-bit code on seg_code and asserts its one-hot enable on dig_sel. Host updates arrive through a valid/ready handshake and are double-buffered, so a new value is only applied at a frame boundary.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 50000, clk cycles per digit slot (>=2)
DEADTIME, 64, blanking cycles at slot start; used only with SEG_SCAN_DEADTIME_EN (1..REFRESH_DIV-1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  scan enable; 0 blanks the display
upd_valid  in  1  host update request
upd_ready  out  1  block can accept an update
upd_data  in  3*NUM_DIGITS  digit codes; digit k = upd_data[3k+2:3k]
seg_code  out  3  code for the current digit, to the shared decoder
dig_sel  out  NUM_DIGITS  one-hot digit enable, active high
frame_done  out  1  one-cycle pulse on scan wrap

Behaviour:
- Reset (rst_n=0, asynchronous): prescaler=0, index=0, active and pending buffers=0, pend_full=0, seg_code=0, dig_sel=0, frame_done=0, upd_ready=1. Reset mid-slot or mid-handshake discards pending data.
- Prescaler counts 0..REFRESH_DIV-1 while enable=1. Terminal count (tc) advances index; index wraps NUM_DIGITS-1 -> 0.
- Frame boundary (fb) = tc while index==NUM_DIGITS-1, or any cycle with enable=0.
- Outputs are registered. Registered index is i: dig_sel=1<<i and seg_code=active[i]. One-cycle latency from an index change to the outputs.
- frame_done=1 in the cycle after a tc that wraps the index. It is never asserted while enable=0.
- Handshake: upd_ready = ~pend_full. Transfer occurs when upd_valid & upd_ready; upd_data is captured into pending and pend_full sets.
- upd_valid may be held high while upd_ready=0. Nothing is captured until upd_ready returns to 1.
- On fb with pend_full=1: active <= pending and pend_full clears. upd_ready is 1 from the next cycle.
- Acceptance in the same cycle as fb with pend_full=0: data lands in pending and is applied at the next fb. It does not bypass pending.
- enable 1->0:
  - dig_sel=0 on the next cycle.
  - prescaler and index synchronously cleared.
  - seg_code holds active[0].
  - Pending data is applied the cycle after acceptance.
- enable 0->1: scan restarts at digit 0, slot counting from 0.
- Codes are passed through unchanged; interpretation of codes 4..7 belongs to the decoder.

Optional Feature:
SEG_SCAN_DEADTIME_EN:
- Defined: dig_sel is forced to 0 for the first DEADTIME cycles of every slot (prescaler < DEADTIME). This suppresses ghosting while seg_code settles; seg_code still changes at the slot start.
- Undefined: dig_sel is active for the whole slot and the DEADTIME parameter is ignored.

Test Plan:
All scenarios use NUM_DIGITS=4 and REFRESH_DIV=4.
- Reset mid-scan: pull rst_n low while dig_sel=0100 -> outputs 0 and upd_ready=1 with no clock edge; after release, first slot is digit 0.
- Free scan: enable=1, no updates -> dig_sel 0001,0010,0100,1000, each for 4 cycles, repeating; seg_code=0; frame_done high 1 cycle every 16 cycles.
- Update: at cycle 5, upd_valid=1 with upd_data=12'b011_010_001_000 -> upd_ready=0 the next cycle; seg_code stays 0 until the frame wrap; then seg_code is 0,1,2,3 for digits 0..3; upd_ready=1 after the wrap.
- Backpressure: hold upd_valid with upd_data=12'hFFF while pend_full=1 -> no capture until the wrap; captured the first cycle upd_ready=1; value 7 shown on all digits one frame later.
- Disable: enable=0 mid-slot -> dig_sel=0000 next cycle, frame_done stays 0; an accepted update appears in active within 2 cycles; re-enable -> dig_sel=0001 first.
- Deadtime (macro defined, DEADTIME=1): each slot shows dig_sel=0 for 1 cycle, then the one-hot value for 3 cycles.
